// File: rtl/lcd_bus_arbiter_if.sv
// Request/grant handshake and LCD pin bundle for lcd_bus_arbiter.
// The requester side uses master; the arbiter uses slave.
interface lcd_bus_arbiter_if;
    logic [3:0]  req_valid;
    logic [3:0]  req_rs;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_en;
    logic        lcd_on;
    logic        init_done;
    logic        busy;

    modport master (
        output req_valid, req_rs, req_data,
        input  req_ready, lcd_data, lcd_rs, lcd_rw,
        input  lcd_en, lcd_on, init_done, busy
    );

    modport slave (
        input  req_valid, req_rs, req_data,
        output req_ready, lcd_data, lcd_rs, lcd_rw,
        output lcd_en, lcd_on, init_done, busy
    );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// Four-requester round-robin arbiter driving an HD44780-style LCD bus,
// with power-on wait and a fixed init sequence before any grant.
module lcd_bus_arbiter #(
    parameter int unsigned POR_WAIT_CYC = 750000,
    parameter int unsigned EN_HIGH_CYC  = 12,
    parameter int unsigned CMD_WAIT_CYC = 2500,
    parameter int unsigned CLR_WAIT_CYC = 82000
) (
    input logic             clock,
    input logic             reset,
    lcd_bus_arbiter_if.slave bus
);
    localparam int unsigned MAX_A = (POR_WAIT_CYC > CLR_WAIT_CYC) ?
                                    POR_WAIT_CYC : CLR_WAIT_CYC;
    localparam int unsigned MAX_B = (MAX_A > CMD_WAIT_CYC) ?
                                    MAX_A : CMD_WAIT_CYC;
    localparam int unsigned MAX_C = (MAX_B > EN_HIGH_CYC) ?
                                    MAX_B : EN_HIGH_CYC;
    localparam int unsigned CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] POR_LAST = CW'(POR_WAIT_CYC - 1);
    localparam logic [CW-1:0] EN_LAST  = CW'(EN_HIGH_CYC - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT_CYC - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WAIT_CYC - 1);

    typedef enum logic [2:0] {
        POR_WAIT, INIT_LOAD, SETUP, PULSE, WAIT, IDLE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    init_idx_q;
    logic [1:0]    last_grant_q;
    logic [7:0]    lcd_data_q;
    logic          lcd_rs_q;
    logic          lcd_en_q;
    logic          init_done_q;
    logic          busy_q;

    logic [3:0]    grant;
    logic [1:0]    grant_idx;
    logic [1:0]    scan_idx;
    logic          found;
    logic [7:0]    init_byte;
    logic [CW-1:0] wait_last;

    // Clear and home commands need the long settle time.
    assign wait_last = (!lcd_rs_q && lcd_data_q[7:2] == 6'd0) ?
                       CLR_LAST : CMD_LAST;

    always_comb begin
        init_byte = 8'h38;
        unique case (init_idx_q)
            2'd0: init_byte = 8'h38;
            2'd1: init_byte = 8'h0C;
            2'd2: init_byte = 8'h06;
            2'd3: init_byte = 8'h01;
        endcase
    end

    // Scan starts one past the last winner; only valid requesters win.
    always_comb begin
        grant     = 4'b0000;
        grant_idx = 2'd0;
        scan_idx  = 2'd0;
        found     = 1'b0;
        if (state_q == IDLE && init_done_q) begin
            for (int k = 1; k <= 4; k++) begin
                scan_idx = last_grant_q + 2'(k);
                if (!found && bus.req_valid[scan_idx]) begin
                    found     = 1'b1;
                    grant_idx = scan_idx;
                end
            end
            if (found) grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= POR_WAIT;
            cnt_q        <= '0;
            init_idx_q   <= 2'd0;
            last_grant_q <= 2'd3;
            lcd_data_q   <= 8'h00;
            lcd_rs_q     <= 1'b0;
            lcd_en_q     <= 1'b0;
            init_done_q  <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            unique case (state_q)
                POR_WAIT: begin
                    if (cnt_q == POR_LAST) begin
                        cnt_q   <= '0;
                        state_q <= INIT_LOAD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                INIT_LOAD: begin
                    lcd_data_q <= init_byte;
                    lcd_rs_q   <= 1'b0;
                    state_q    <= SETUP;
                end
                SETUP: begin
                    lcd_en_q <= 1'b1;
                    cnt_q    <= '0;
                    state_q  <= PULSE;
                end
                PULSE: begin
                    if (cnt_q == EN_LAST) begin
                        lcd_en_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= WAIT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q == wait_last) begin
                        cnt_q <= '0;
                        if (init_done_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else if (init_idx_q == 2'd3) begin
                            init_done_q <= 1'b1;
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                        end else begin
                            init_idx_q <= init_idx_q + 2'd1;
                            state_q    <= INIT_LOAD;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (|grant) begin
                        lcd_data_q   <= bus.req_data[{grant_idx, 3'b000} +: 8];
                        lcd_rs_q     <= bus.req_rs[grant_idx];
                        last_grant_q <= grant_idx;
                        busy_q       <= 1'b1;
                        state_q      <= SETUP;
                    end
                end
                default: state_q <= POR_WAIT;
            endcase
        end
    end

    assign bus.req_ready = grant;
    assign bus.lcd_data  = lcd_data_q;
    assign bus.lcd_rs    = lcd_rs_q;
    assign bus.lcd_rw    = 1'b0;
    assign bus.lcd_en    = lcd_en_q;
    assign bus.lcd_on    = 1'b1;
    assign bus.init_done = init_done_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Scoreboard bench for lcd_bus_arbiter: stimulus queues expected grants
// and LCD bytes, a negedge monitor pops and checks them.
module tb_lcd_bus_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;

    lcd_bus_arbiter_if bus ();

    lcd_bus_arbiter #(
        .POR_WAIT_CYC(4),
        .EN_HIGH_CYC (2),
        .CMD_WAIT_CYC(3),
        .CLR_WAIT_CYC(6)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // wait_c: WAIT cycles; ovh: extra low cycles before the next init
    // pulse (INIT_LOAD + SETUP), 0 when the byte ends in IDLE.
    typedef struct {
        logic [7:0] data;
        logic       rs;
        int         wait_c;
        int         ovh;
    } byte_t;

    byte_t      bq[$];
    logic [3:0] gq[$];
    int total = 0;
    int bad   = 0;
    int ngrant = 0;
    int cyc = 0;
    int gcyc = 0;
    int mst = 0;
    int hi = 0;
    int lo = 0;
    bit stable = 1'b1;
    byte_t cur;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail_to(input string name, input int waited);
        total++;
        bad++;
        $display("FAIL %s: timed out after %0d cycles", name, waited);
    endtask

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            mst = 0;
        end else begin
            if (bus.req_ready != 4'b0000) begin
                ngrant++;
                gcyc = cyc;
                if (gq.size() == 0) check("grant_unexpected", bus.req_ready, 0);
                else check("grant", bus.req_ready, gq.pop_front());
            end
            if (!bus.init_done && bus.req_valid != 4'b0000)
                check("ready_gated", bus.req_ready, 0);
            if (mst == 2) begin
                if (bus.lcd_en || !bus.busy) begin
                    check("wait_len", lo, cur.wait_c + cur.ovh);
                    check("bus_stable", stable, 1);
                    mst = 0;
                end else begin
                    lo++;
                    if (lo <= cur.wait_c &&
                        (bus.lcd_data != cur.data || bus.lcd_rs != cur.rs))
                        stable = 1'b0;
                end
            end
            if (mst == 1) begin
                if (bus.lcd_data != cur.data || bus.lcd_rs != cur.rs)
                    stable = 1'b0;
                if (bus.lcd_en) begin
                    hi++;
                end else begin
                    check("en_width", hi, 2);
                    lo = 1;
                    mst = 2;
                end
            end
            if (mst == 0 && bus.lcd_en) begin
                if (bq.size() == 0) begin
                    check("byte_unexpected", bq.size(), 1);
                end else begin
                    cur = bq.pop_front();
                    check("lcd_data", bus.lcd_data, cur.data);
                    check("lcd_rs", bus.lcd_rs, cur.rs);
                    check("lcd_rw", bus.lcd_rw, 0);
                    check("lcd_on", bus.lcd_on, 1);
                    // IDLE grant -> SETUP -> first PULSE cycle
                    if (cur.ovh == 0 && cur.wait_c != 6 || cur.rs)
                        if (bus.init_done) check("grant_to_en", cyc - gcyc, 2);
                    hi = 1;
                    stable = 1'b1;
                    mst = 1;
                end
            end
        end
    end

    task automatic push_init();
        bq.push_back('{8'h38, 1'b0, 3, 2});
        bq.push_back('{8'h0C, 1'b0, 3, 2});
        bq.push_back('{8'h06, 1'b0, 3, 2});
        bq.push_back('{8'h01, 1'b0, 6, 0});
    endtask

    task automatic wait_grant(input int i);
        int n;
        n = 0;
        while (n < 300) begin
            @(negedge clock);
            if (bus.req_ready[i]) break;
            n++;
        end
        if (n >= 300) fail_to("grant_wait", n);
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (n < 300) begin
            @(posedge clock);
            #1;
            if (mst == 0 && bq.size() == 0 && gq.size() == 0 && !bus.busy)
                break;
            n++;
        end
        if (n >= 300) fail_to("drain", n);
    endtask

    task automatic send(input int i, input bit rs, input logic [7:0] d,
                        input int w);
        gq.push_back(4'(1 << i));
        bq.push_back('{d, rs, w, 0});
        bus.req_rs[i] = rs;
        bus.req_data[8*i +: 8] = d;
        bus.req_valid[i] = 1'b1;
        wait_grant(i);
        bus.req_valid[i] = 1'b0;
        drain();
    endtask

    task automatic check_reset_state();
        check("rst_en", bus.lcd_en, 0);
        check("rst_data", bus.lcd_data, 0);
        check("rst_rs", bus.lcd_rs, 0);
        check("rst_rw", bus.lcd_rw, 0);
        check("rst_on", bus.lcd_on, 1);
        check("rst_init_done", bus.init_done, 0);
        check("rst_busy", bus.busy, 1);
        check("rst_ready", bus.req_ready, 0);
    endtask

    initial begin
        int n;
        int base;
        bus.req_valid = 4'b0000;
        bus.req_rs    = 4'b0000;
        bus.req_data  = 32'h0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_reset_state();

        // Requester 3 valid through init: no grant until init_done.
        push_init();
        gq.push_back(4'b1000);
        bq.push_back('{8'h55, 1'b1, 3, 0});
        bus.req_rs[3] = 1'b1;
        bus.req_data[31:24] = 8'h55;
        bus.req_valid[3] = 1'b1;
        reset = 1'b0;

        // 4 POR cycles, INIT_LOAD, SETUP, then lcd_en rises.
        n = 0;
        while (n < 50) begin
            @(posedge clock);
            #1;
            n++;
            if (bus.lcd_en) break;
        end
        check("por_latency", n, 6);

        wait_grant(3);
        bus.req_valid[3] = 1'b0;
        drain();
        check("init_done", bus.init_done, 1);

        // All four continuously valid from last_grant=3.
        for (int i = 0; i < 4; i++) begin
            bus.req_data[8*i +: 8] = 8'hA0 + 8'(i);
            bus.req_rs[i] = i[0];
        end
        gq.push_back(4'b0001);
        gq.push_back(4'b0010);
        gq.push_back(4'b0100);
        gq.push_back(4'b1000);
        gq.push_back(4'b0001);
        bq.push_back('{8'hA0, 1'b0, 3, 0});
        bq.push_back('{8'hA1, 1'b1, 3, 0});
        bq.push_back('{8'hA2, 1'b0, 3, 0});
        bq.push_back('{8'hA3, 1'b1, 3, 0});
        bq.push_back('{8'hA0, 1'b0, 3, 0});
        base = ngrant;
        bus.req_valid = 4'b1111;
        n = 0;
        while (n < 400) begin
            @(posedge clock);
            #1;
            if (ngrant >= base + 5) break;
            n++;
        end
        if (n >= 400) fail_to("rr_grants", n);
        bus.req_valid = 4'b0000;
        drain();

        send(2, 1'b1, 8'h41, 3);
        send(1, 1'b0, 8'h01, 6);
        send(1, 1'b0, 8'h80, 3);
        send(1, 1'b0, 8'h03, 6);
        send(1, 1'b0, 8'h04, 3);
        send(1, 1'b1, 8'h01, 3);

        // Reset in the first PULSE cycle of a user byte.
        bus.req_data[7:0] = 8'h77;
        bus.req_rs[0] = 1'b1;
        gq.push_back(4'b0001);
        bus.req_valid[0] = 1'b1;
        wait_grant(0);
        bus.req_valid[0] = 1'b0;
        n = 0;
        while (n < 20) begin
            @(posedge clock);
            #1;
            if (bus.lcd_en) break;
            n++;
        end
        if (n >= 20) fail_to("pulse_wait", n);
        reset = 1'b1;
        bq.delete();
        gq.delete();
        @(posedge clock);
        #1;
        check_reset_state();
        push_init();
        reset = 1'b0;
        n = 0;
        while (n < 200) begin
            @(posedge clock);
            #1;
            if (bus.init_done) break;
            n++;
        end
        if (n >= 200) fail_to("reinit", n);
        drain();
        check("reinit_done", bus.init_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
